mantissa_cmp_arbiter: RTL and testbench

//  Shares one compare_mantissas instance between N_REQ requesters (e.g. adder lanes, the normaliser

---
 rtl/mhub_cmp_pkg.sv | 17 +
 rtl/compare_mantissas.sv | 14 +
 rtl/mantissa_cmp_arbiter.sv | 120 ++++++++++++
 tb/tb_mantissa_cmp_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mhub_cmp_pkg.sv
// Shared types and helpers for the mantissa compare arbiter.
//   cmp_arb_state_t : arbiter FSM state encoding
//   idx_w()         : width of the owner / round-robin pointer for a requester count
package mhub_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_arb_state_t;

    // The pointer is at least 1 bit wide, even for two requesters.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/compare_mantissas.sv
// Unsigned magnitude compare of two unpacked "1.M" mantissas.
//   mx, my : M+1 bit operands
//   gt_c   : combinational flag, 1 when mx > my (equal gives 0)
module compare_mantissas #(
    parameter int unsigned M = 23
) (
    input  logic [M:0] mx,
    input  logic [M:0] my,
    output logic       gt_c
);

    assign gt_c = (mx > my);

endmodule

// File: rtl/mantissa_cmp_arbiter.sv
// Round-robin arbiter that shares one mantissa comparator between N_REQ requesters.
// One transaction at a time: IDLE (grant + latch) -> CMP (compare) -> RESP (hold result).
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester operand-pair valid
//   req_ready   : one-hot combinational grant, only while IDLE
//   req_mx/my   : packed operands, requester i at [i*(M+1) +: M+1]
//   rsp_valid   : one-hot registered result valid for the owning requester
//   rsp_ready   : per-requester result accept; only the owner's bit is observed
//   rsp_gt      : registered result, 1 when Mx > My
//   busy        : high whenever a transaction is in flight
module mantissa_cmp_arbiter
    import mhub_cmp_pkg::*;
#(
    parameter int unsigned M     = 23,
    parameter int unsigned N_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*(M+1)-1:0] req_mx,
    input  logic [N_REQ*(M+1)-1:0] req_my,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic                   rsp_gt,
    output logic                   busy
);

    localparam int unsigned W     = M + 1;
    localparam int unsigned IDX_W = idx_w(N_REQ);

    cmp_arb_state_t   state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [W-1:0]     mx_q;
    logic [W-1:0]     my_q;

    logic [IDX_W-1:0] winner;
    logic             found;
    int unsigned      idx;
    logic [W-1:0]     win_mx;
    logic [W-1:0]     win_my;
    logic             cmp_gt_c;

    // Round-robin search starting just after the last winner, wrapping at N_REQ.
    always_comb begin
        winner    = '0;
        found     = 1'b0;
        idx       = 0;
        req_ready = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = 32'(last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
        if (state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Only the winner's operands are selected, so other lanes never reach the result.
    always_comb begin
        win_mx = req_mx[32'(winner) * W +: W];
        win_my = req_my[32'(winner) * W +: W];
    end

    compare_mantissas #(.M(M)) u_cmp (
        .mx   (mx_q),
        .my   (my_q),
        .gt_c (cmp_gt_c)
    );

    // Arbiter FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDX_W'(N_REQ - 1);
            owner     <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            rsp_valid <= '0;
            rsp_gt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mx_q  <= win_mx;
                        my_q  <= win_my;
                        owner <= winner;
                        last  <= winner;
                        state <= CMP;
                    end
                end
                CMP: begin
                    rsp_gt    <= cmp_gt_c;
                    rsp_valid <= N_REQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mantissa_cmp_arbiter.sv
// Self-checking bench for mantissa_cmp_arbiter: a 2-requester and a 4-requester instance
// checked against a round-robin / unsigned-compare reference model.
module tb_mantissa_cmp_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n2, rst_n4;
    logic [1:0]  v2, rdy2, rv2, rr2;
    logic [47:0] mx2, my2;
    logic        gt2, busy2;
    logic [3:0]  v4, rdy4, rv4, rr4;
    logic [95:0] mx4, my4;
    logic        gt4, busy4;

    int checks   = 0;
    int failures = 0;
    int last2    = 1;
    int last4    = 3;

    mantissa_cmp_arbiter #(.M(23), .N_REQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .req_valid(v2), .req_ready(rdy2),
        .req_mx(mx2), .req_my(my2), .rsp_valid(rv2), .rsp_ready(rr2),
        .rsp_gt(gt2), .busy(busy2)
    );

    mantissa_cmp_arbiter #(.M(23), .N_REQ(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .req_valid(v4), .req_ready(rdy4),
        .req_mx(mx4), .req_my(my4), .rsp_valid(rv4), .rsp_ready(rr4),
        .rsp_gt(gt4), .busy(busy4)
    );

    // Reference arbitration: first valid requester after the previous winner, modulo n.
    function automatic int rr_pick(input int last, input int n, input logic [7:0] v);
        for (int k = 1; k <= n; k++) begin
            if (v[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    task automatic reset2();
        rst_n2 = 1'b0; v2 = '0; rr2 = '0; mx2 = '0; my2 = '0;
        repeat (2) @(negedge clk);
        rst_n2 = 1'b1;
        last2  = 1;
        @(negedge clk);
    endtask

    // One full transaction on the 2-requester instance; starts and ends just after a falling edge.
    task automatic do_txn2(input logic [1:0] v, input logic [23:0] a0, input logic [23:0] b0,
                           input logic [23:0] a1, input logic [23:0] b1, input int hold,
                           input bit rr_all, output int w);
        logic [1:0]  oh;
        logic        eg;
        v2  = v;
        mx2 = {a1, a0};
        my2 = {b1, b0};
        rr2 = '0;
        w   = rr_pick(last2, 2, {6'b0, v});
        oh  = 2'(1 << w);
        eg  = (w == 0) ? (a0 > b0) : (a1 > b1);
        #1;
        checks++;
        if (rdy2 !== oh) begin failures++; $display("FAIL grant2 ready=%b expected=%b", rdy2, oh); end
        @(posedge clk);
        last2 = w;
        @(negedge clk);
        v2 = '0;
        #1;
        checks++;
        if (busy2 !== 1'b1 || rv2 !== 2'b00 || rdy2 !== 2'b00) begin
            failures++;
            $display("FAIL cmp_phase busy=%b rsp_valid=%b ready=%b expected 1/00/00", busy2, rv2, rdy2);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rv2 !== oh || gt2 !== eg) begin
            failures++;
            $display("FAIL resp2 rsp_valid=%b gt=%b expected %b/%b", rv2, gt2, oh, eg);
        end
        for (int i = 0; i < hold; i++) begin
            rr2 = ~oh;
            v2  = 2'b11;
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (rv2 !== oh || gt2 !== eg || rdy2 !== 2'b00 || busy2 !== 1'b1) begin
                failures++;
                $display("FAIL hold2 cyc=%0d rsp_valid=%b gt=%b ready=%b busy=%b expected %b/%b/00/1",
                         i, rv2, gt2, rdy2, busy2, oh, eg);
            end
        end
        v2  = '0;
        rr2 = rr_all ? 2'b11 : oh;
        @(posedge clk);
        @(negedge clk);
        rr2 = '0;
        #1;
        checks++;
        if (rv2 !== 2'b00 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL release2 rsp_valid=%b busy=%b expected 00/0", rv2, busy2);
        end
    endtask

    task automatic test_reset();
        rst_n2 = 1'b0; rst_n4 = 1'b0;
        v2 = '0; rr2 = '0; mx2 = '0; my2 = '0;
        v4 = '0; rr4 = '0; mx4 = '0; my4 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy2 !== 2'b00 || rv2 !== 2'b00 || gt2 !== 1'b0 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL in_reset ready=%b rsp_valid=%b gt=%b busy=%b expected all 0", rdy2, rv2, gt2, busy2);
        end
        rst_n2 = 1'b1; rst_n4 = 1'b1;
        last2 = 1; last4 = 3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rdy2 !== 2'b00 || rv2 !== 2'b00 || gt2 !== 1'b0 || busy2 !== 1'b0
                || rdy4 !== 4'b0 || rv4 !== 4'b0 || busy4 !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d ready=%b rsp_valid=%b gt=%b busy=%b expected all 0",
                         i, rdy2, rv2, gt2, busy2);
            end
        end
    endtask

    task automatic test_single();
        int w;
        do_txn2(2'b01, 24'hC00000, 24'h800000, 24'h0, 24'h0, 0, 1'b1, w);
    endtask

    task automatic test_back_to_back();
        int w;
        int exp_order [4] = '{0, 1, 0, 1};
        reset2();
        for (int i = 0; i < 4; i++) begin
            do_txn2(2'b11, 24'(i * 3 + 5), 24'(i), 24'(i), 24'(i * 7 + 1), 0, 1'b1, w);
            checks++;
            if (w !== exp_order[i]) begin
                failures++;
                $display("FAIL order txn=%0d winner=%0d expected=%0d", i, w, exp_order[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        int w;
        do_txn2(2'b01, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 0, 1'b0, w);
        do_txn2(2'b10, 24'h0, 24'h0, 24'h800000, 24'h800001, 0, 1'b0, w);
        do_txn2(2'b01, 24'h800001, 24'h800000, 24'h0, 24'h0, 0, 1'b0, w);
        do_txn2(2'b10, 24'h0, 24'h0, 24'hFFFFFF, 24'h000000, 0, 1'b0, w);
        do_txn2(2'b01, 24'h000000, 24'hFFFFFF, 24'h0, 24'h0, 0, 1'b0, w);
    endtask

    task automatic test_stall();
        int w;
        do_txn2(2'b10, 24'h0, 24'h0, 24'h123456, 24'h123455, 7, 1'b0, w);
    endtask

    task automatic test_random();
        int w;
        logic [1:0]  v;
        logic [23:0] a0, b0, a1, b1;
        for (int i = 0; i < 24; i++) begin
            v  = 2'($urandom_range(1, 3));
            a0 = 24'($urandom); b0 = 24'($urandom);
            a1 = 24'($urandom); b1 = 24'($urandom);
            if ($urandom_range(0, 3) == 0) b0 = a0;
            if ($urandom_range(0, 3) == 0) b1 = a1;
            if (!v[0]) begin a0 = 'x; b0 = 'x; end
            if (!v[1]) begin a1 = 'x; b1 = 'x; end
            do_txn2(v, a0, b0, a1, b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)), w);
        end
    endtask

    task automatic test_reset_mid_resp();
        int w;
        logic [3:0] oh;
        logic       eg;
        logic [23:0] a [4];
        logic [23:0] b [4];
        @(negedge clk);
        v4  = 4'b0100;
        mx4 = {24'h0, 24'h000001, 24'h0, 24'h0};
        my4 = {24'h0, 24'h000002, 24'h0, 24'h0};
        w   = rr_pick(last4, 4, {4'b0, v4});
        #1;
        checks++;
        if (rdy4 !== 4'b0100 || w != 2) begin
            failures++;
            $display("FAIL grant4_owner2 ready=%b expected=0100", rdy4);
        end
        @(posedge clk);
        @(negedge clk);
        v4 = '0;
        @(posedge clk);
        @(negedge clk);
        rr4 = 4'b1011;
        #1;
        checks++;
        if (rv4 !== 4'b0100 || gt4 !== 1'b0) begin
            failures++;
            $display("FAIL resp4 rsp_valid=%b gt=%b expected 0100/0", rv4, gt4);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rv4 !== 4'b0100 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL nonowner_ready4 rsp_valid=%b busy=%b expected 0100/1", rv4, busy4);
        end
        rst_n4 = 1'b0;
        #1;
        checks++;
        if (rv4 !== 4'b0 || busy4 !== 1'b0 || gt4 !== 1'b0 || rdy4 !== 4'b0) begin
            failures++;
            $display("FAIL reset4_clear rsp_valid=%b busy=%b gt=%b ready=%b expected all 0",
                     rv4, busy4, gt4, rdy4);
        end
        @(negedge clk);
        rst_n4 = 1'b1;
        rr4    = '0;
        last4  = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rv4 !== 4'b0 || busy4 !== 1'b0) begin
                failures++;
                $display("FAIL stale4 cyc=%0d rsp_valid=%b busy=%b expected 0000/0", i, rv4, busy4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            a[i] = 24'($urandom);
            b[i] = 24'($urandom);
        end
        v4  = 4'b1111;
        mx4 = {a[3], a[2], a[1], a[0]};
        my4 = {b[3], b[2], b[1], b[0]};
        w   = rr_pick(last4, 4, {4'b0, v4});
        oh  = 4'(1 << w);
        eg  = a[w] > b[w];
        #1;
        checks++;
        if (rdy4 !== oh || w != 0) begin
            failures++;
            $display("FAIL post_reset_grant4 ready=%b expected=0001", rdy4);
        end
        @(posedge clk);
        last4 = w;
        @(negedge clk);
        v4 = 4'b1110;
        #1;
        checks++;
        if (rdy4 !== 4'b0 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL cmp4 ready=%b busy=%b expected 0000/1", rdy4, busy4);
        end
        @(posedge clk);
        @(negedge clk);
        rr4 = oh;
        #1;
        checks++;
        if (rv4 !== oh || gt4 !== eg) begin
            failures++;
            $display("FAIL resp4_post rsp_valid=%b gt=%b expected %b/%b", rv4, gt4, oh, eg);
        end
        @(posedge clk);
        @(negedge clk);
        rr4 = '0;
        w   = rr_pick(last4, 4, {4'b0, v4});
        #1;
        checks++;
        if (rv4 !== 4'b0 || rdy4 !== 4'(1 << w)) begin
            failures++;
            $display("FAIL next_grant4 rsp_valid=%b ready=%b expected 0000/%b", rv4, rdy4, 4'(1 << w));
        end
        v4 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_boundaries();
        test_stall();
        test_random();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
